// File: rtl/segment_transition_controller_pkg.sv
// -----------------------------------------------------------------------------
// segment_transition_controller_pkg
// Shared types and constants for the segment transition controller:
//   transition_mode_t  - MODE encoding carried on the update interface
//   state_t            - controller state encoding
//   REP_INFINITE       - loop count value meaning "repeat forever"
//   mode_to_state()    - maps a non-EXT MODE onto its wait state
//   rep_for()          - selects the loop count belonging to a segment
// Optional feature macro: SEGMENT_TRANSITION_GPIO_EN (enables GPIO mode).
// -----------------------------------------------------------------------------
package segment_transition_controller_pkg;

  typedef enum logic [7:0] {
    MODE_SYNC_IDX = 8'h00,
    MODE_SYS_TIME = 8'h01,
    MODE_GPIO     = 8'h02,
    MODE_EXT      = 8'hF0
  } transition_mode_t;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_WAIT_TIME = 3'd2,
    ST_WAIT_GPIO = 3'd3,
    ST_EXT       = 3'd4
  } state_t;

  localparam logic [15:0] REP_INFINITE = 16'hFFFF;

  // Unknown modes fall back to index-synchronous switching; without the GPIO
  // feature, GPIO mode does the same.
  function automatic state_t mode_to_state(input logic [7:0] mode);
    state_t st;
    case (mode)
      MODE_SYS_TIME: st = ST_WAIT_TIME;
`ifdef SEGMENT_TRANSITION_GPIO_EN
      MODE_GPIO:     st = ST_WAIT_GPIO;
`endif
      default:       st = ST_WAIT_SYNC;
    endcase
    return st;
  endfunction

  function automatic logic [15:0] rep_for(input logic seg, input logic [15:0] r0,
                                          input logic [15:0] r1);
    return seg ? r1 : r0;
  endfunction

endpackage

// File: rtl/segment_transition_controller_gpio_edge_sync.sv
// -----------------------------------------------------------------------------
// gpio_edge_sync
// Two-flop synchronizer for asynchronous GPIO triggers followed by a
// registered rising-edge detector (one-cycle pulse per synchronized edge).
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   gpio_in  in   [WIDTH] asynchronous trigger pins
//   rise     out  [WIDTH] one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module gpio_edge_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] rise_r;

  // Synchronizer chain and registered edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      sync_r <= '0;
      prev_r <= '0;
      rise_r <= '0;
    end else begin
      meta_r <= gpio_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
      rise_r <= sync_r & ~prev_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/segment_transition_controller.sv
// -----------------------------------------------------------------------------
// segment_transition_controller
// Decides when the sampling datapath switches between its two segments.
// An UPDATE requests a segment and a transition mode; the controller waits for
// the mode's trigger (index wrap, system time or GPIO edge), then switches the
// active segment with a one-cycle START. It also counts segment loops and
// raises STOP when finite loops run out; in EXT mode it instead ping-pongs
// between the segments on loop exhaustion.
// Optional feature macro: SEGMENT_TRANSITION_GPIO_EN (GPIO trigger mode).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   update             one-cycle request strobe (samples the fields below)
//   req_segment, mode, value, rep0, rep1   request fields
//   idx_wrap           datapath index wrapped to 0
//   sys_time           free-running system time
//   gpio_in            asynchronous GPIO triggers
//   segment, start, stop, busy             registered status outputs
// -----------------------------------------------------------------------------
module segment_transition_controller
  import segment_transition_controller_pkg::*;
#(
  parameter int NUM_GPIO       = 4,
  parameter int SYS_TIME_WIDTH = 57
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      update,
  input  logic                      req_segment,
  input  logic [7:0]                mode,
  input  logic [63:0]               value,
  input  logic [15:0]               rep0,
  input  logic [15:0]               rep1,
  input  logic                      idx_wrap,
  input  logic [SYS_TIME_WIDTH-1:0] sys_time,
  input  logic [NUM_GPIO-1:0]       gpio_in,
  output logic                      segment,
  output logic                      start,
  output logic                      stop,
  output logic                      busy
);

  state_t                    state_r, state_s;
  logic                      segment_r, segment_s;
  logic                      start_r, start_s;
  logic                      stop_r, stop_s;
  logic                      busy_r, busy_s;
  logic [15:0]               cnt_r, cnt_s;
  logic                      req_seg_r, req_seg_s;
  logic [SYS_TIME_WIDTH-1:0] target_r, target_s;
  logic [15:0]               rep0_r, rep0_s;
  logic [15:0]               rep1_r, rep1_s;
  logic                      stopped_r, stopped_s;  // STOP was high when the request arrived
  logic                      trigger_s;
  logic                      gpio_rise_s;
  logic                      unused_s;

`ifdef SEGMENT_TRANSITION_GPIO_EN
  logic [NUM_GPIO-1:0] gpio_rise_vec_s;
  logic [1:0]          gpio_sel_r;

  gpio_edge_sync #(.WIDTH(NUM_GPIO)) u_gpio_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .gpio_in (gpio_in),
    .rise    (gpio_rise_vec_s)
  );

  // Captures which GPIO pin the pending request listens to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_sel_r <= 2'd0;
    end else if (update) begin
      gpio_sel_r <= value[1:0];
    end else begin
      gpio_sel_r <= gpio_sel_r;
    end
  end

  assign gpio_rise_s = gpio_rise_vec_s[gpio_sel_r];
  assign unused_s    = ^value[63:SYS_TIME_WIDTH];
`else
  assign gpio_rise_s = 1'b0;
  assign unused_s    = ^{value[63:SYS_TIME_WIDTH], gpio_in};
`endif

  // Trigger condition of the current wait state.
  always_comb begin
    trigger_s = 1'b0;
    case (state_r)
      ST_WAIT_SYNC: trigger_s = idx_wrap | stopped_r;
      ST_WAIT_TIME: trigger_s = (sys_time >= target_r);
      ST_WAIT_GPIO: trigger_s = gpio_rise_s;
      default:      trigger_s = 1'b0;
    endcase
  end

  // Next-state and output logic; UPDATE outranks any trigger or wrap.
  always_comb begin
    state_s   = state_r;
    segment_s = segment_r;
    start_s   = 1'b0;
    stop_s    = stop_r;
    busy_s    = busy_r;
    cnt_s     = cnt_r;
    req_seg_s = req_seg_r;
    target_s  = target_r;
    rep0_s    = rep0_r;
    rep1_s    = rep1_r;
    stopped_s = stopped_r;
    if (update) begin
      req_seg_s = req_segment;
      target_s  = value[SYS_TIME_WIDTH-1:0];
      rep0_s    = rep0;
      rep1_s    = rep1;
      stop_s    = 1'b0;
      stopped_s = 1'b0;
      if (mode == MODE_EXT) begin
        state_s   = ST_EXT;
        segment_s = req_segment;
        start_s   = 1'b1;
        busy_s    = 1'b0;
        cnt_s     = rep_for(req_segment, rep0, rep1);
      end else if (req_segment == segment_r) begin
        state_s = ST_RUN;
        busy_s  = 1'b0;
        cnt_s   = rep_for(req_segment, rep0, rep1);
      end else begin
        state_s   = mode_to_state(mode);
        busy_s    = 1'b1;
        stopped_s = stop_r;
      end
    end else if (trigger_s) begin
      state_s   = ST_RUN;
      segment_s = req_seg_r;
      start_s   = 1'b1;
      stop_s    = 1'b0;
      busy_s    = 1'b0;
      stopped_s = 1'b0;
      cnt_s     = rep_for(req_seg_r, rep0_r, rep1_r);
    end else if (idx_wrap && (cnt_r != REP_INFINITE) &&
                 ((state_r == ST_RUN) || (state_r == ST_EXT))) begin
      if (cnt_r != 16'd0) begin
        cnt_s = cnt_r - 16'd1;
      end else if (state_r == ST_EXT) begin
        // Loops exhausted in EXT: swap to the other segment and restart it.
        segment_s = ~segment_r;
        start_s   = 1'b1;
        cnt_s     = rep_for(~segment_r, rep0_r, rep1_r);
      end else begin
        stop_s = 1'b1;
      end
    end else begin
      state_s = state_r;
    end
  end

  // Controller state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      segment_r <= 1'b0;
      start_r   <= 1'b0;
      stop_r    <= 1'b0;
      busy_r    <= 1'b0;
      cnt_r     <= REP_INFINITE;
      req_seg_r <= 1'b0;
      target_r  <= '0;
      rep0_r    <= 16'd0;
      rep1_r    <= 16'd0;
      stopped_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      segment_r <= segment_s;
      start_r   <= start_s;
      stop_r    <= stop_s;
      busy_r    <= busy_s;
      cnt_r     <= cnt_s;
      req_seg_r <= req_seg_s;
      target_r  <= target_s;
      rep0_r    <= rep0_s;
      rep1_r    <= rep1_s;
      stopped_r <= stopped_s;
    end
  end

  assign segment = segment_r;
  assign start   = start_r;
  assign stop    = stop_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_segment_transition_controller.sv
// -----------------------------------------------------------------------------
// tb_segment_transition_controller
// Directed bench: every expected START (cycle and segment) is queued when the
// stimulus that should cause it is driven, and popped when START is observed.
// Level outputs (SEGMENT/STOP/BUSY) are checked directly after each step.
// Build with SEGMENT_TRANSITION_GPIO_EN to exercise the GPIO trigger path.
// -----------------------------------------------------------------------------
module tb_segment_transition_controller;

  localparam int STW = 57;

  logic            clk_s = 1'b0;
  logic            rst_n_s;
  logic            update_s;
  logic            req_segment_s;
  logic [7:0]      mode_s;
  logic [63:0]     value_s;
  logic [15:0]     rep0_s;
  logic [15:0]     rep1_s;
  logic            idx_wrap_s;
  logic [STW-1:0]  sys_time_s;
  logic [3:0]      gpio_in_s;
  logic            segment_s;
  logic            start_s;
  logic            stop_s;
  logic            busy_s;

  typedef struct {
    int unsigned cyc;
    logic        seg;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  segment_transition_controller #(.NUM_GPIO(4), .SYS_TIME_WIDTH(STW)) dut (
    .clk         (clk_s),
    .rst_n       (rst_n_s),
    .update      (update_s),
    .req_segment (req_segment_s),
    .mode        (mode_s),
    .value       (value_s),
    .rep0        (rep0_s),
    .rep1        (rep1_s),
    .idx_wrap    (idx_wrap_s),
    .sys_time    (sys_time_s),
    .gpio_in     (gpio_in_s),
    .segment     (segment_s),
    .start       (start_s),
    .stop        (stop_s),
    .busy        (busy_s)
  );

  // Free-running clock.
  always #5 clk_s = ~clk_s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample #1 after the edge, advance system time, score any START.
  task automatic step();
    exp_t ev;
    @(posedge clk_s);
    #1;
    cyc++;
    sys_time_s = sys_time_s + 1'b1;
    if (start_s === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_start observed=1 expected=0 cycle=%0d", cyc);
      end
      if (sb.size() != 0) begin
        ev = sb.pop_front();
        check("start_cycle", 64'(cyc), 64'(ev.cyc));
        check("start_segment", {63'd0, segment_s}, {63'd0, ev.seg});
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_start(input int unsigned at, input logic seg);
    exp_t ev;
    ev.cyc = at;
    ev.seg = seg;
    sb.push_back(ev);
  endtask

  task automatic do_update(input logic seg, input logic [7:0] md, input logic [63:0] val,
                           input logic [15:0] r0, input logic [15:0] r1);
    update_s      = 1'b1;
    req_segment_s = seg;
    mode_s        = md;
    value_s       = val;
    rep0_s        = r0;
    rep1_s        = r1;
    step();
    update_s      = 1'b0;
  endtask

  task automatic wrap();
    idx_wrap_s = 1'b1;
    step();
    idx_wrap_s = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic seg, input logic stp, input logic bsy);
    check({tag, "_segment"}, {63'd0, segment_s}, {63'd0, seg});
    check({tag, "_stop"},    {63'd0, stop_s},    {63'd0, stp});
    check({tag, "_busy"},    {63'd0, busy_s},    {63'd0, bsy});
  endtask

  initial begin
    rst_n_s = 1'b0; update_s = 1'b0; req_segment_s = 1'b0; mode_s = 8'h00;
    value_s = 64'd0; rep0_s = 16'd0; rep1_s = 16'd0; idx_wrap_s = 1'b0;
    sys_time_s = '0; gpio_in_s = 4'd0;
    steps(2);
    rst_n_s = 1'b1;
    check("reset_start", {63'd0, start_s}, 64'd0);
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    steps(2);

    // Case 1: sync-index switch 10 cycles after the request.
    do_update(1'b1, 8'h00, 64'd0, 16'hFFFF, 16'hFFFF);
    check_outs("c1_pending", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step();
      check("c1_busy_hold", {63'd0, busy_s}, 64'd1);
    end
    push_start(cyc + 1, 1'b1);
    wrap();
    check_outs("c1_switched", 1'b1, 1'b0, 1'b0);
    step();
    check("c1_start_one_cycle", {63'd0, start_s}, 64'd0);

    // Case 2: system-time target 100 ticks ahead, then one in the past.
    push_start(cyc + 1 + 100, 1'b0);
    do_update(1'b0, 8'h01, 64'(sys_time_s) + 64'd100, 16'hFFFF, 16'hFFFF);
    check_outs("c2_pending", 1'b1, 1'b0, 1'b1);
    steps(100);
    check_outs("c2_switched", 1'b0, 1'b0, 1'b0);
    push_start(cyc + 2, 1'b1);
    do_update(1'b1, 8'h01, 64'd5, 16'hFFFF, 16'hFFFF);
    check("c2_past_busy", {63'd0, busy_s}, 64'd1);
    step();
    check_outs("c2_past_switched", 1'b1, 1'b0, 1'b0);

    // Case 3: three loops on segment 1, STOP, then a sync switch away.
    do_update(1'b1, 8'h00, 64'd0, 16'hFFFF, 16'd2);
    check_outs("c3_reload", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wrap();
      step();
      check("c3_stop", {63'd0, stop_s}, (i >= 2) ? 64'd1 : 64'd0);
    end
    push_start(cyc + 2, 1'b0);
    do_update(1'b0, 8'h00, 64'd0, 16'hFFFF, 16'hFFFF);
    check_outs("c3_pending", 1'b1, 1'b0, 1'b1);
    step();
    check_outs("c3_switched", 1'b0, 1'b0, 1'b0);

    // Case 4: EXT ping-pong with REP0=0, REP1=1.
    push_start(cyc + 1, 1'b0);
    do_update(1'b0, 8'hF0, 64'd0, 16'd0, 16'd1);
    check_outs("c4_enter", 1'b0, 1'b0, 1'b0);
    push_start(cyc + 1, 1'b1);
    wrap(); step();
    check_outs("c4_wrap1", 1'b1, 1'b0, 1'b0);
    wrap(); step();
    check_outs("c4_wrap2", 1'b1, 1'b0, 1'b0);
    push_start(cyc + 1, 1'b0);
    wrap(); step();
    check_outs("c4_wrap3", 1'b0, 1'b0, 1'b0);

    // Case 5: GPIO mode on pin 2; a pulse on pin 1 must not switch.
    do_update(1'b1, 8'h02, 64'd2, 16'hFFFF, 16'hFFFF);
    check_outs("c5_pending", 1'b0, 1'b0, 1'b1);
    gpio_in_s = 4'b0010;
    steps(3);
    gpio_in_s = 4'b0000;
    steps(3);
    check_outs("c5_wrong_pin", 1'b0, 1'b0, 1'b1);
`ifdef SEGMENT_TRANSITION_GPIO_EN
    push_start(cyc + 4, 1'b1);
    gpio_in_s = 4'b0100;
    steps(3);
    gpio_in_s = 4'b0000;
    steps(3);
    check_outs("c5_switched", 1'b1, 1'b0, 1'b0);
`else
    gpio_in_s = 4'b0100;
    steps(3);
    gpio_in_s = 4'b0000;
    steps(3);
    check_outs("c5_gpio_ignored", 1'b0, 1'b0, 1'b1);
    push_start(cyc + 1, 1'b1);
    wrap();
    check_outs("c5_switched", 1'b1, 1'b0, 1'b0);
`endif

    // Case 6: reset during WAIT_TIME abandons the request.
    do_update(1'b0, 8'h01, 64'(sys_time_s) + 64'd50, 16'hFFFF, 16'hFFFF);
    steps(5);
    check("c6_busy_before_reset", {63'd0, busy_s}, 64'd1);
    rst_n_s = 1'b0;
    #1;
    check("c6_reset_start", {63'd0, start_s}, 64'd0);
    check_outs("c6_in_reset", 1'b0, 1'b0, 1'b0);
    steps(2);
    rst_n_s = 1'b1;
    steps(80);
    check_outs("c6_after_release", 1'b0, 1'b0, 1'b0);

    check("pending_starts", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
